// File: rtl/qarmav2_inv_round_engine.sv
// rtl/qarmav2_inv_round_engine.sv - iterative QARMAv2-128 inverse-round engine
// One inverse round per clock; tweakeys are fetched by index from ROUNDS-1 down to 0.
module qarmav2_inv_round_engine #(
    parameter int ROUNDS = 9,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic [IDX_W-1:0] tk_idx,
    input  logic [127:0]     tk_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy,
    input  logic             clear
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [127:0]     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h8;  4'h1: y = 4'ha;  4'h2: y = 4'he;  4'h3: y = 4'hd;
            4'h4: y = 4'h0;  4'h5: y = 4'h9;  4'h6: y = 4'h5;  4'h7: y = 4'h1;
            4'h8: y = 4'hc;  4'h9: y = 4'h2;  4'ha: y = 4'hf;  4'hb: y = 4'h3;
            4'hc: y = 4'h4;  4'hd: y = 4'hb;  4'he: y = 4'h6;  default: y = 4'h7;
        endcase
        return y;
    endfunction

    function automatic logic [127:0] inv_sub_cells(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[4*i +: 4] = inv_sbox(s[4*i +: 4]);
        return o;
    endfunction

    function automatic logic [3:0] rho1(input logic [3:0] x);
        return {x[2:0], x[3]};
    endfunction

    function automatic logic [3:0] rho2(input logic [3:0] x);
        return {x[1:0], x[3:2]};
    endfunction

    // Column j holds cells 4j..4j+3; circ(0, rho, rho^2, rho) is an involution.
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [3:0]   a [4];
        o = '0;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[4*(4*c+r) +: 4];
            for (int r = 0; r < 4; r++)
                o[4*(4*c+r) +: 4] = rho1(a[(r+1)%4]) ^ rho2(a[(r+2)%4]) ^ rho1(a[(r+3)%4]);
        end
        return o;
    endfunction

    // Forward shuffle takes out[i] = in[(5i+3) mod 32]; this scatters it back.
    function automatic logic [127:0] inv_shuffle_cells(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 32; i++) o[4*((5*i+3)%32) +: 4] = s[4*i +: 4];
        return o;
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] tk, input logic [127:0] s);
        return tk ^ inv_shuffle_cells(mix_columns(inv_sub_cells(s)));
    endfunction

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        tk_idx    = '0;
        busy      = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    fsm_d   = RUN;
                    state_d = in_data;
                    idx_d   = IDX_W'(ROUNDS - 1);
                end
            end
            RUN: begin
                busy    = 1'b1;
                tk_idx  = idx_q;
                state_d = inv_round(tk_in, state_q);
                if (idx_q == '0) fsm_d = DONE;
                else             idx_d = idx_q - 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = state_q;
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
        // Abort beats any handshake, including a same-cycle accept.
        if (clear) begin
            fsm_d   = IDLE;
            state_d = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            idx_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule
